// File: rtl/rv_pipe_pkg.sv
// Shared RV pipeline constants: forward source encodings, result-ready stages, shadow entry layout.
// Purely declarative; no timing and no flow control of its own.
// Consumers import it to agree on fwd_entry_t and on how result-ready stages are normalised.
package rv_pipe_pkg;

    localparam int REG_AW     = 5;
    localparam int FWD_SRC_RF = 0;
    localparam int FWD_SRC_M  = 1;
    localparam int FWD_SRC_WB = 2;

    localparam logic [2:0] RDY_ALU  = 3'd1;
    localparam logic [2:0] RDY_LOAD = 3'd2;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic [2:0]        rdy;
    } fwd_entry_t;

    // A result can never be ready before stage 1, and once it reaches the last
    // tracked stage it must be ready, so clamp into 1..depth.
    function automatic logic [2:0] clamp_rdy(input logic [2:0] rdy, input int depth);
        logic [2:0] d;
        d = 3'(depth);
        if (rdy == 3'd0) return RDY_ALU;
        if (rdy > d) return d;
        return rdy;
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port priority match: youngest shadow stage writing rs gives sel; late if its data is not yet produced.
// Fully combinational, zero cycles.
// No flow control; the late flag feeds the top-level stall OR.
module fwd_port_sel
    import rv_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic [REG_AW-1:0]        rs,
    input  fwd_entry_t [DEPTH-1:0]   stages,
    output logic [SEL_W-1:0]         sel,
    output logic                     late
);

    // Scan oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        sel  = SEL_W'(FWD_SRC_RF);
        late = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (stages[k-1].vld && (stages[k-1].rd == rs) && (rs != '0)) begin
                sel  = SEL_W'(k);
                late = int'(stages[k-1].rdy) > k;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard unit: DEPTH-stage shadow pipe of post-EX writers, youngest-match select, late-result stall; FWD_STALL_CNT_EN adds a stall counter.
// Latency: fwd_sel_o/stall_o are combinational from EX inputs and shadow state; shadow pipe advances every clk unless hold_i.
// Backpressure: stall_o holds IF/ID/EX and injects a bubble into stage 1; hold_i freezes the shadow pipe entirely.
module fwd_hazard_unit #(
    parameter  int REG_AW = rv_pipe_pkg::REG_AW,
    parameter  int NUM_RP = 2,
    parameter  int DEPTH  = 2,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold_i,
    input  logic                     flush_i,
    input  logic                     ex_valid_i,
    input  logic [NUM_RP*REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0]        ex_rd_i,
    input  logic                     ex_regwrite_i,
    input  logic [2:0]               ex_rdy_i,
    output logic [NUM_RP*SEL_W-1:0]  fwd_sel_o,
    output logic                     stall_o,
    output logic [31:0]              stall_cnt_o
);

    rv_pipe_pkg::fwd_entry_t [DEPTH-1:0] stages;
    rv_pipe_pkg::fwd_entry_t             ex_entry;
    logic [NUM_RP-1:0]                   late;

    for (genvar p = 0; p < NUM_RP; p++) begin : g_port
        fwd_port_sel #(
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_sel (
            .rs     (ex_rs_i[p*REG_AW +: REG_AW]),
            .stages (stages),
            .sel    (fwd_sel_o[p*SEL_W +: SEL_W]),
            .late   (late[p])
        );
    end

    assign stall_o = ex_valid_i & ~flush_i & (|late);

    always_comb begin
        ex_entry     = '0;
        ex_entry.vld = ex_regwrite_i;
        ex_entry.rd  = ex_rd_i;
        ex_entry.rdy = rv_pipe_pkg::clamp_rdy(ex_rdy_i, DEPTH);
    end

    // Stage DEPTH falls off the end: the regfile is write-first, so it is visible there the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else if (!hold_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                stages[k] <= stages[k-1];
            end
            if (stall_o || flush_i || !ex_valid_i) begin
                stages[0] <= '0;
            end else begin
                stages[0] <= ex_entry;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_o && !hold_i && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
